// File: rtl/seq_chk_pkg.sv
// Shared types and defaults for the count sequence checker.
// Optional error counter is enabled by defining SEQ_CHK_ERRCNT_EN.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNCING  = 2'd1,
    LOCKED   = 2'd2
  } seq_state_t;

  localparam int unsigned WIDTH_DEF    = 5;
  localparam int unsigned SYNC_LEN_DEF = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; increment wins over clear.
// Used for err_count when SEQ_CHK_ERRCNT_EN is defined.
module sat_counter
  import seq_chk_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      if (count != '1) count <= count + W'(1);
    end else if (clr) begin
      count <= '0;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Locks onto an up-counter's q stream and flags departures from +1 mod 2^WIDTH.
// Define SEQ_CHK_ERRCNT_EN to add the saturating err_count output.
module count_seq_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned SYNC_LEN   = SYNC_LEN_DEF,
  parameter bit          ALLOW_ZERO = 1'b1
`ifdef SEQ_CHK_ERRCNT_EN
  ,
  parameter int unsigned ERRW       = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [WIDTH-1:0] expected
`ifdef SEQ_CHK_ERRCNT_EN
  ,
  output logic [ERRW-1:0]  err_count
`endif
);

  localparam int unsigned GW = $clog2(SYNC_LEN + 1);

  seq_state_t       state;
  logic [WIDTH-1:0] prev;
  logic [GW-1:0]    good_cnt;
  logic             mism_pend;
  logic [WIDTH-1:0] exp_val;

  always_comb begin
    exp_val = prev + WIDTH'(1);
  end

  // mism_pend holds the sample-edge verdict; mismatch/locked/err state follow one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= UNLOCKED;
      prev       <= '0;
      good_cnt   <= '0;
      mism_pend  <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      expected   <= '0;
    end else begin
      locked    <= (state == LOCKED);
      mismatch  <= mism_pend;
      mism_pend <= 1'b0;
      if (mism_pend)    err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;
      if (valid) expected <= exp_val;

      case (state)
        UNLOCKED: begin
          if (valid) begin
            prev     <= q;
            good_cnt <= '0;
            state    <= SYNCING;
          end
        end
        SYNCING: begin
          if (valid) begin
            prev <= q;
            if (q == exp_val) begin
              if (good_cnt == GW'(SYNC_LEN - 1)) begin
                good_cnt <= '0;
                state    <= LOCKED;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (valid) begin
            if (q == exp_val) begin
              prev <= q;
            end else if (ALLOW_ZERO && (q == '0)) begin
              prev <= '0;
            end else begin
              mism_pend <= 1'b1;
              prev      <= q;
              good_cnt  <= '0;
              state     <= SYNCING;
            end
          end
        end
        default: begin
          good_cnt <= '0;
          state    <= UNLOCKED;
        end
      endcase
    end
  end

`ifdef SEQ_CHK_ERRCNT_EN
  sat_counter #(.W(ERRW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mism_pend),
    .clr   (clr_err),
    .count (err_count)
  );
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker with an expectation queue per stimulus step.
// err_count checks are active when SEQ_CHK_ERRCNT_EN is defined.
module tb_count_seq_checker;

  logic       clk;
  logic       reset;
  logic [4:0] q;
  logic       valid;
  logic       clr_err;

  logic       locked, mismatch, err_sticky;
  logic [4:0] expected;
  logic       nz_locked, nz_mismatch, nz_err_sticky;
  logic [4:0] nz_expected;
`ifdef SEQ_CHK_ERRCNT_EN
  logic [1:0] err_count;
  logic [1:0] nz_err_count;
`endif

  count_seq_checker #(
    .WIDTH      (5),
    .SYNC_LEN   (2),
    .ALLOW_ZERO (1'b1)
`ifdef SEQ_CHK_ERRCNT_EN
    , .ERRW     (2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q          (q),
    .valid      (valid),
    .clr_err    (clr_err),
    .locked     (locked),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .expected   (expected)
`ifdef SEQ_CHK_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  count_seq_checker #(
    .WIDTH      (5),
    .SYNC_LEN   (2),
    .ALLOW_ZERO (1'b0)
`ifdef SEQ_CHK_ERRCNT_EN
    , .ERRW     (2)
`endif
  ) dut_nz (
    .clk        (clk),
    .reset      (reset),
    .q          (q),
    .valid      (valid),
    .clr_err    (clr_err),
    .locked     (nz_locked),
    .mismatch   (nz_mismatch),
    .err_sticky (nz_err_sticky),
    .expected   (nz_expected)
`ifdef SEQ_CHK_ERRCNT_EN
    , .err_count(nz_err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  el, em, es;
    int    ee;
    int    ecnt;
    bit    chk_nz;
    logic  enz;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "/locked"},     32'(locked),        32'd0);
    chk({tag, "/mismatch"},   32'(mismatch),      32'd0);
    chk({tag, "/err_sticky"}, 32'(err_sticky),    32'd0);
    chk({tag, "/expected"},   32'(expected),      32'd0);
    chk({tag, "/nz_locked"},  32'(nz_locked),     32'd0);
    chk({tag, "/nz_sticky"},  32'(nz_err_sticky), 32'd0);
`ifdef SEQ_CHK_ERRCNT_EN
    chk({tag, "/err_count"},  32'(err_count),     32'd0);
`endif
  endtask

  // Drive one sample; the pushed entry is what the outputs must show after this edge.
  task automatic step(input string tag, input int qv, input bit v, input bit c,
                      input bit el, input bit em, input bit es, input int ee, input int ecnt,
                      input bit chk_nz = 1'b0, input bit enz = 1'b0);
    exp_t e;
    @(negedge clk);
    q       = qv[4:0];
    valid   = v;
    clr_err = c;
    e.tag = tag; e.el = el; e.em = em; e.es = es; e.ee = ee; e.ecnt = ecnt;
    e.chk_nz = chk_nz; e.enz = enz;
    sb.push_back(e);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk({cur.tag, "/locked"},     32'(locked),     32'(cur.el));
      chk({cur.tag, "/mismatch"},   32'(mismatch),   32'(cur.em));
      chk({cur.tag, "/err_sticky"}, 32'(err_sticky), 32'(cur.es));
      chk({cur.tag, "/expected"},   32'(expected),   32'(cur.ee % 32));
`ifdef SEQ_CHK_ERRCNT_EN
      chk({cur.tag, "/err_count"},  32'(err_count),  32'(cur.ecnt));
`endif
      if (cur.chk_nz) chk({cur.tag, "/nz_mismatch"}, 32'(nz_mismatch), 32'(cur.enz));
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset   = 1'b1;
    valid   = 1'b0;
    clr_err = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p;
    int a;
    reset   = 1'b1;
    q       = '0;
    valid   = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_init");
    reset = 1'b0;

    // Lock-on: locked rises one edge after the SYNC_LEN-th good sample.
    step("t1_s3", 3, 1, 0, 0, 0, 0, 1, 0);
    step("t1_s4", 4, 1, 0, 0, 0, 0, 4, 0);
    step("t1_s5", 5, 1, 0, 0, 0, 0, 5, 0);
    step("t1_s6", 6, 1, 0, 1, 0, 0, 6, 0);
    step("t1_s7", 7, 1, 0, 1, 0, 0, 7, 0);

    // Run through the 31 -> 0 wrap.
    for (int k = 8; k <= 33; k++) step("t2_run", k, 1, 0, 1, 0, 0, k, 0);
    for (int k = 2; k <= 10; k++) step("t3_run", k, 1, 0, 1, 0, 0, k, 0);

    // Bad sample 14 after 10, then relock on 15,16,17 and clear.
    step("t3_bad",    14, 1, 0, 1, 0, 0, 11, 0);
    step("t3_pulse",  15, 1, 0, 0, 1, 1, 15, 1);
    step("t3_sync16", 16, 1, 0, 0, 0, 1, 16, 1);
    step("t3_relock", 17, 1, 0, 1, 0, 1, 17, 1);
    step("t3_clr",    18, 1, 1, 1, 0, 0, 18, 0);

    do_reset("reset_mid");

    // Counter reset to 0 while locked: legal only with ALLOW_ZERO.
    step("t4_s9",  9,  1, 0, 0, 0, 0, 1,  0, 1, 0);
    step("t4_s10", 10, 1, 0, 0, 0, 0, 10, 0, 1, 0);
    step("t4_s11", 11, 1, 0, 0, 0, 0, 11, 0, 1, 0);
    step("t4_s12", 12, 1, 0, 1, 0, 0, 12, 0, 1, 0);
    step("t4_z0",  0,  1, 0, 1, 0, 0, 13, 0, 1, 0);
    step("t4_z1",  1,  1, 0, 1, 0, 0, 1,  0, 1, 1);
    step("t4_z2",  2,  1, 0, 1, 0, 0, 2,  0, 1, 0);

    // Invalid cycles with garbage q must not disturb anything.
    for (int k = 0; k < 5; k++)
      step("t5_hold", int'($urandom_range(20, 31)), 0, 0, 1, 0, 0, 2, 0);
    step("t5_r3", 3, 1, 0, 1, 0, 0, 3, 0);
    step("t5_r4", 4, 1, 0, 1, 0, 0, 4, 0);
    step("t5_r5", 5, 1, 0, 1, 0, 0, 5, 0);

    // Repeated mismatches: bad, then two good samples to relock.
    p = 5;
    for (int r = 1; r <= 5; r++) begin
      a = p + 10;
      step("t6_bad",    a,     1, 0, 1, 0, (r > 1), p + 1, (r - 1 > 3) ? 3 : r - 1);
      step("t6_pulse",  a + 1, 1, 0, 0, 1, 1,       a + 1, (r > 3) ? 3 : r);
      step("t6_resync", a + 2, 1, 0, 0, 0, 1,       a + 2, (r > 3) ? 3 : r);
      p = a + 2;
    end
    step("t6_bad6",    75, 1, 0, 1, 0, 1, 66, 3);
    step("t6_setwins", 76, 1, 1, 0, 1, 1, 76, 3);
    step("t6_resync6", 77, 1, 0, 0, 0, 1, 77, 3);
    step("t6_clr",     78, 1, 1, 1, 0, 0, 78, 0);
    step("t6_bad7",    88, 1, 0, 1, 0, 0, 79, 0);
    step("t6_pulse7",  89, 1, 0, 0, 1, 1, 89, 1);
    step("t6_sync7",   90, 1, 0, 0, 0, 1, 90, 1);
    step("t6_lock7",   91, 1, 0, 1, 0, 1, 91, 1);

    // Asynchronous reset while locked with sticky set.
    #3;
    reset = 1'b1;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
